// File: rtl/me_block_loader.sv
// me_block_loader
//   Streams one 16x16 reference block followed by one 31x31 search window
//   into two pixel memories, waits a fixed number of idle cycles, then runs
//   the motion estimation core until it reports done (or the host aborts).
//
// Ports
//   in_clk, in_rst_n          clock (rising edge), asynchronous active-low reset
//   in_start                  begin a load-and-run sequence (honoured in IDLE only)
//   in_abort                  cancel the current sequence (non-IDLE states)
//   in_pix_valid/in_pix_data  pixel stream: RB pixels, then SW pixels, raster order
//   out_pix_ready             high while loading; beat accepted on valid & ready
//   out_rb_write_*            reference block memory write port (registered)
//   out_sw_write_*            search window memory write port (registered)
//   out_me_enable             enable to the motion estimation core
//   in_me_done, in_min_sad    core completion and its minimum SAD
//   out_min_sad               SAD captured on completion
//   out_done                  one-cycle completion pulse
//   out_run_cycles            cycles out_me_enable was high in the last/current run
module me_block_loader #(
  parameter int DATA_WIDTH      = 8,
  parameter int RB_MEMORY_DEPTH = 256,
  parameter int SW_MEMORY_DEPTH = 961,
  parameter int MAX_DATA_WIDTH  = 16,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                               in_clk,
  input  logic                               in_rst_n,
  input  logic                               in_start,
  input  logic                               in_abort,
  input  logic                               in_pix_valid,
  input  logic [DATA_WIDTH-1:0]              in_pix_data,
  output logic                               out_pix_ready,
  output logic                               out_rb_write_en,
  output logic [$clog2(RB_MEMORY_DEPTH)-1:0] out_rb_write_addr,
  output logic [DATA_WIDTH-1:0]              out_rb_write_data,
  output logic                               out_sw_write_en,
  output logic [$clog2(SW_MEMORY_DEPTH)-1:0] out_sw_write_addr,
  output logic [DATA_WIDTH-1:0]              out_sw_write_data,
  output logic                               out_me_enable,
  input  logic                               in_me_done,
  input  logic [MAX_DATA_WIDTH-1:0]          in_min_sad,
  output logic [MAX_DATA_WIDTH-1:0]          out_min_sad,
  output logic                               out_done,
  output logic [31:0]                        out_run_cycles
);

  localparam int RB_AW = $clog2(RB_MEMORY_DEPTH);
  localparam int SW_AW = $clog2(SW_MEMORY_DEPTH);
  localparam int CNT_W = (RB_AW > SW_AW) ? RB_AW : SW_AW;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_RB,
    S_LOAD_SW,
    S_GAP,
    S_RUN
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   beat_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               accept;
  logic               rb_last;
  logic               sw_last;
  logic               gap_over;
  logic               finish;

  // Ready and enable are pure state decodes, so an asynchronous reset of the
  // state register drops them immediately without waiting for a clock edge.
  assign out_pix_ready = (state == S_LOAD_RB) || (state == S_LOAD_SW);
  assign out_me_enable = (state == S_RUN);

  // A beat presented in the abort cycle is discarded.
  assign accept   = out_pix_ready && in_pix_valid && !in_abort;
  assign rb_last  = (beat_cnt == CNT_W'(RB_MEMORY_DEPTH - 1));
  assign sw_last  = (beat_cnt == CNT_W'(SW_MEMORY_DEPTH - 1));
  // GAP is entered on the cycle the final SW write is visible; counting up to
  // GAP_CYCLES there leaves exactly GAP_CYCLES idle cycles before RUN.
  assign gap_over = (gap_cnt == GAP_W'(GAP_CYCLES));
  // Abort has priority over a simultaneous core completion.
  assign finish   = (state == S_RUN) && in_me_done && !in_abort;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next takes a default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (in_start) state_next = S_LOAD_RB;
      end
      S_LOAD_RB: begin
        if (in_abort)              state_next = S_IDLE;
        else if (accept && rb_last) state_next = S_LOAD_SW;
      end
      S_LOAD_SW: begin
        if (in_abort)              state_next = S_IDLE;
        else if (accept && sw_last) state_next = S_GAP;
      end
      S_GAP: begin
        if (in_abort)      state_next = S_IDLE;
        else if (gap_over) state_next = S_RUN;
      end
      S_RUN: begin
        if (in_abort || in_me_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Beat index within the memory currently being loaded, and the GAP timer.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      beat_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (in_start) beat_cnt <= '0;
      end else if (accept) begin
        if ((state == S_LOAD_RB && rb_last) || (state == S_LOAD_SW && sw_last)) begin
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end

      if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else                gap_cnt <= '0;
    end
  end

  // Registered memory write ports: one write per accepted beat, one cycle
  // later. Only one load state is active at a time, so the two ports can
  // never be enabled together.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_rb_write_en   <= 1'b0;
      out_rb_write_addr <= '0;
      out_rb_write_data <= '0;
      out_sw_write_en   <= 1'b0;
      out_sw_write_addr <= '0;
      out_sw_write_data <= '0;
    end else begin
      out_rb_write_en <= accept && (state == S_LOAD_RB);
      out_sw_write_en <= accept && (state == S_LOAD_SW);
      if (accept && state == S_LOAD_RB) begin
        out_rb_write_addr <= beat_cnt[RB_AW-1:0];
        out_rb_write_data <= in_pix_data;
      end
      if (accept && state == S_LOAD_SW) begin
        out_sw_write_addr <= beat_cnt[SW_AW-1:0];
        out_sw_write_data <= in_pix_data;
      end
    end
  end

  // Run statistics and result capture.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_run_cycles <= '0;
      out_min_sad    <= '0;
      out_done       <= 1'b0;
    end else begin
      out_done <= finish;
      if (finish) out_min_sad <= in_min_sad;

      if (state == S_IDLE && in_start) begin
        out_run_cycles <= '0;
      end else if (state == S_RUN && out_run_cycles != 32'hFFFF_FFFF) begin
        out_run_cycles <= out_run_cycles + 32'd1;
      end
    end
  end

endmodule
